lidar_gen: RTL and testbench
============================

LIDAR_GEN -- requirements
Module: lidar_gen

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the width of lidar_data.
REQ-002 The block SHALL have parameter CNT_W, default 12, meaning the width of the sample count, gap and index fields.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all logic is on the rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide; reset is synchronous and active-high.
REQ-005 Port start SHALL be an input, 1 bit wide; it is a one-cycle request to begin generation.
REQ-006 Port stop SHALL be an input, 1 bit wide; it is a one-cycle request to abort generation.
REQ-007 Port cfg_mode SHALL be an input, 2 bits wide: 0 = constant, 1 = ramp, 2 = LFSR, 3 = reserved.
REQ-008 Port cfg_seed SHALL be an input, DATA_W bits wide, and is the initial data value.
REQ-009 Port cfg_samples SHALL be an input, CNT_W bits wide, and is the number of samples per frame.
REQ-010 Port cfg_gap SHALL be an input, 8 bits wide, and is the number of idle cycles between samples.
REQ-011 Port cfg_frame_gap SHALL be an input, CNT_W bits wide, and is the number of idle cycles between frames.
REQ-012 Port cfg_cont SHALL be an input, 1 bit wide; 1 = continuous frames, 0 = single frame.
REQ-013 Port lidar_data SHALL be an output, DATA_W bits wide, and is the sample data.
REQ-014 Port valid SHALL be an output, 1 bit wide, and qualifies lidar_data for one cycle.
REQ-015 Port busy SHALL be an output, 1 bit wide, and is high in any state other than IDLE.
REQ-016 Port frame_done SHALL be an output, 1 bit wide; it pulses for one cycle with the last sample of a frame.
REQ-017 Port sample_idx SHALL be an output, CNT_W bits wide, and is the index within the frame of the current sample.
REQ-018 Port frame_cnt SHALL be an output, 16 bits wide, and counts completed frames, wrapping.

Function
REQ-019 The FSM SHALL have states IDLE, SEND, GAP and FGAP; all outputs SHALL be registered.
REQ-020 In IDLE, a start with cfg_samples != 0 SHALL latch all cfg_* inputs and enter SEND; a start with cfg_samples == 0 SHALL be ignored.
REQ-021 When start is sampled at edge k, the first valid SHALL be high in the cycle following edge k+1, i.e. one-cycle latency.
REQ-022 SEND SHALL assert valid for exactly one cycle per sample; sample_idx SHALL equal 0..cfg_samples-1 in order.
REQ-023 After a non-last sample, the FSM SHALL enter GAP for cfg_gap cycles with valid low when the latched gap is non-zero; otherwise it SHALL stay in SEND for back-to-back samples.
REQ-024 On the last sample, frame_done SHALL be high in the same cycle as valid, and frame_cnt SHALL increment by 1 (mod 2^16).
REQ-025 After the last sample with cfg_cont=1, the FSM SHALL enter FGAP for cfg_frame_gap cycles (straight to SEND if 0) and reuse the latched config; with cfg_cont=0 it SHALL go to IDLE.
REQ-026 Mode 0 SHALL output lidar_data = seed for every sample.
REQ-027 Mode 1 SHALL output lidar_data = seed + sample_idx, mod 2^DATA_W, restarting at seed each frame.
REQ-028 Mode 2 SHALL output lidar_data from the LFSR (see Configuration).
REQ-029 Mode 3 SHALL behave as mode 0.
REQ-030 A stop input in any non-IDLE state SHALL force valid low from the next cycle and return the FSM to IDLE; frame_done SHALL not pulse and frame_cnt SHALL be unchanged.
REQ-031 If start and stop are high together in IDLE, stop SHALL win and the FSM SHALL stay in IDLE.
REQ-032 A start input outside IDLE SHALL be ignored.
REQ-033 cfg_* changes while busy SHALL have no effect until the next start.
REQ-034 When cfg_samples = 1, every sample SHALL be both first and last; frame_done SHALL accompany each valid.

Reset
REQ-035 While rst is high at a clock edge, the FSM SHALL go to IDLE and lidar_data, valid, busy, frame_done, sample_idx and frame_cnt SHALL all be 0.
REQ-036 Reset mid-frame SHALL abort the frame with no further valid; reset SHALL take priority over start and stop.

Configuration
REQ-037 The macro LIDAR_GEN_LFSR_EN, when defined, SHALL enable mode 2.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1.
- Loaded with seed at start; a seed of 0 is replaced by 16'hACE1.
- Output is the current state; the LFSR advances once per valid sample.
- The LFSR is not reseeded between frames.
- Requires DATA_W = 16.
REQ-038 When LIDAR_GEN_LFSR_EN is not defined, no LFSR logic SHALL exist and mode 2 SHALL behave as mode 1 (ramp).

Verification
REQ-039 Mode 1, seed=100, samples=4, gap=0, cont=0 -> valid on 4 consecutive cycles starting 1 cycle after start; data 100,101,102,103; frame_done with 103; frame_cnt=1; busy low after.
REQ-040 Mode 0, seed=16'h00FF, samples=3, gap=2 -> valid pattern 1,0,0,1,0,0,1; all data 16'h00FF.
REQ-041 Mode 1, seed=16'hFFFE, samples=3 -> data FFFE, FFFF, 0000 (wrap).
REQ-042 cont=1, samples=2, frame_gap=3; stop asserted after the 3rd frame_done -> 3 frame_done pulses with 3 idle cycles between frames, then IDLE; frame_cnt=3.
REQ-043 stop during a gap of the 2nd sample of 5 -> no valid after, frame_done never pulses, frame_cnt=0.
REQ-044 Mode 2, seed=0 with LIDAR_GEN_LFSR_EN defined -> first data 16'hACE1 and the sequence matches a reference LFSR model; without the macro -> ramp data 0,1,2,...

Source files
------------

// File: rtl/lidar_gen.sv
// Synthetic lidar sample generator: constant, ramp or LFSR data in gapped frames.
// Optional LFSR data mode (cfg_mode 2) is compiled in when LIDAR_GEN_LFSR_EN is defined.
module lidar_gen #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        cfg_mode,
    input  logic [DATA_W-1:0] cfg_seed,
    input  logic [CNT_W-1:0]  cfg_samples,
    input  logic [7:0]        cfg_gap,
    input  logic [CNT_W-1:0]  cfg_frame_gap,
    input  logic              cfg_cont,
    output logic [DATA_W-1:0] lidar_data,
    output logic              valid,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  sample_idx,
    output logic [15:0]       frame_cnt
);

    typedef enum logic [1:0] {IDLE, SEND, GAP, FGAP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [CNT_W-1:0]  samples_q, samples_d;
    logic [7:0]        gap_q, gap_d;
    logic [CNT_W-1:0]  fgap_q, fgap_d;
    logic              cont_q, cont_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic [CNT_W-1:0]  sample_idx_q, sample_idx_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0] sample_val;
    logic              last_sample;

`ifdef LIDAR_GEN_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    // Taps 16,14,13,11 in right-shifting Fibonacci form
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
`endif

    assign last_sample = (idx_q == samples_q - CNT_W'(1));

    always_comb begin
        sample_val = seed_q;
        case (mode_q)
            2'd1: sample_val = seed_q + DATA_W'(idx_q);
`ifdef LIDAR_GEN_LFSR_EN
            2'd2: sample_val = lfsr_q;
`else
            2'd2: sample_val = seed_q + DATA_W'(idx_q);
`endif
            default: sample_val = seed_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        seed_d       = seed_q;
        samples_d    = samples_q;
        gap_d        = gap_q;
        fgap_d       = fgap_q;
        cont_d       = cont_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;
        sample_idx_d = sample_idx_q;
        frame_cnt_d  = frame_cnt_q;
`ifdef LIDAR_GEN_LFSR_EN
        lfsr_d       = lfsr_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !stop && (cfg_samples != '0)) begin
                    mode_d    = cfg_mode;
                    seed_d    = cfg_seed;
                    samples_d = cfg_samples;
                    gap_d     = cfg_gap;
                    fgap_d    = cfg_frame_gap;
                    cont_d    = cfg_cont;
                    idx_d     = '0;
                    state_d   = SEND;
`ifdef LIDAR_GEN_LFSR_EN
                    lfsr_d    = (cfg_seed == '0) ? 16'hACE1 : cfg_seed[15:0];
`endif
                end
            end
            SEND: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    valid_d      = 1'b1;
                    data_d       = sample_val;
                    sample_idx_d = idx_q;
`ifdef LIDAR_GEN_LFSR_EN
                    lfsr_d       = {lfsr_fb, lfsr_q[15:1]};
`endif
                    if (last_sample) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                        idx_d        = '0;
                        if (!cont_q) begin
                            state_d = IDLE;
                        end else if (fgap_q != '0) begin
                            state_d = FGAP;
                            cnt_d   = fgap_q;
                        end
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                        if (gap_q != 8'd0) begin
                            state_d = GAP;
                            cnt_d   = CNT_W'(gap_q);
                        end
                    end
                end
            end
            GAP, FGAP: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = SEND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= '0;
            seed_q       <= '0;
            samples_q    <= '0;
            gap_q        <= '0;
            fgap_q       <= '0;
            cont_q       <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            sample_idx_q <= '0;
            frame_cnt_q  <= '0;
`ifdef LIDAR_GEN_LFSR_EN
            lfsr_q       <= 16'hACE1;
`endif
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            seed_q       <= seed_d;
            samples_q    <= samples_d;
            gap_q        <= gap_d;
            fgap_q       <= fgap_d;
            cont_q       <= cont_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            sample_idx_q <= sample_idx_d;
            frame_cnt_q  <= frame_cnt_d;
`ifdef LIDAR_GEN_LFSR_EN
            lfsr_q       <= lfsr_d;
`endif
        end
    end

    assign lidar_data = data_q;
    assign valid      = valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign sample_idx = sample_idx_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_lidar_gen.sv
// Directed bench for lidar_gen: timing, data modes, frame sequencing, stop and reset.
module tb_lidar_gen;

    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_seed;
    logic [11:0] cfg_samples;
    logic [7:0]  cfg_gap;
    logic [11:0] cfg_frame_gap;
    logic        cfg_cont;
    logic [15:0] lidar_data;
    logic        valid, busy, frame_done;
    logic [11:0] sample_idx;
    logic [15:0] frame_cnt;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [15:0] q_data[$];
    logic [11:0] q_idx[$];
    int          q_cyc[$];
    logic        q_fd[$];

    lidar_gen #(.DATA_W(16), .CNT_W(12)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_mode(cfg_mode), .cfg_seed(cfg_seed), .cfg_samples(cfg_samples),
        .cfg_gap(cfg_gap), .cfg_frame_gap(cfg_frame_gap), .cfg_cont(cfg_cont),
        .lidar_data(lidar_data), .valid(valid), .busy(busy),
        .frame_done(frame_done), .sample_idx(sample_idx), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            q_data.push_back(lidar_data);
            q_idx.push_back(sample_idx);
            q_cyc.push_back(cyc);
            q_fd.push_back(frame_done);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [15:0] sd, input logic [11:0] n,
                           input logic [7:0] g, input logic [11:0] fg, input logic c);
        cfg_mode = m; cfg_seed = sd; cfg_samples = n;
        cfg_gap = g; cfg_frame_gap = fg; cfg_cont = c;
    endtask

    task automatic clr();
        q_data.delete(); q_idx.delete(); q_cyc.delete(); q_fd.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clr();
    endtask

    task automatic go(output int s);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        s = cyc;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic b;
        b = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {b, v[15:1]};
    endfunction

    initial begin
        int s;
        int fd_sum;
        logic [15:0] m;
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        set_cfg(2'd0, 16'd0, 12'd0, 8'd0, 12'd0, 1'b0);

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", lidar_data, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_idx", sample_idx, 0);
        chk("rst_fcnt", frame_cnt, 0);
        rst = 1'b0;

        // ramp, back-to-back, config changes while busy ignored
        do_reset();
        set_cfg(2'd1, 16'd100, 12'd4, 8'd0, 12'd0, 1'b0);
        go(s);
        set_cfg(2'd0, 16'h5555, 12'd7, 8'd5, 12'd5, 1'b1);
        repeat (15) @(negedge clk);
        chk("ramp_n", q_data.size(), 4);
        for (int i = 0; i < q_data.size(); i++) begin
            chk("ramp_data", q_data[i], 100 + i);
            chk("ramp_idx", q_idx[i], i);
            chk("ramp_cyc", q_cyc[i], s + 1 + i);
            chk("ramp_fd", q_fd[i], (i == 3) ? 1 : 0);
        end
        chk("ramp_fcnt", frame_cnt, 1);
        chk("ramp_busy", busy, 0);

        // constant with gap 2, second start while busy ignored
        do_reset();
        set_cfg(2'd0, 16'h00FF, 12'd3, 8'd2, 12'd0, 1'b0);
        go(s);
        @(negedge clk);
        cfg_seed = 16'h1234;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (15) @(negedge clk);
        chk("gap_n", q_data.size(), 3);
        for (int i = 0; i < q_data.size(); i++) begin
            chk("gap_data", q_data[i], 16'h00FF);
            chk("gap_cyc", q_cyc[i], s + 1 + 3 * i);
        end
        chk("gap_fcnt", frame_cnt, 1);

        // ramp wrap
        do_reset();
        set_cfg(2'd1, 16'hFFFE, 12'd3, 8'd0, 12'd0, 1'b0);
        go(s);
        repeat (8) @(negedge clk);
        chk("wrap_n", q_data.size(), 3);
        if (q_data.size() == 3) begin
            chk("wrap_d0", q_data[0], 16'hFFFE);
            chk("wrap_d1", q_data[1], 16'hFFFF);
            chk("wrap_d2", q_data[2], 16'h0000);
        end

        // samples == 0 ignored
        do_reset();
        set_cfg(2'd1, 16'd5, 12'd0, 8'd0, 12'd0, 1'b0);
        go(s);
        repeat (3) @(negedge clk);
        chk("zero_busy", busy, 0);
        chk("zero_n", q_data.size(), 0);

        // start and stop together: stop wins
        do_reset();
        set_cfg(2'd1, 16'd5, 12'd4, 8'd0, 12'd0, 1'b0);
        @(negedge clk) begin start = 1'b1; stop = 1'b1; end
        @(negedge clk) begin start = 1'b0; stop = 1'b0; end
        repeat (5) @(negedge clk);
        chk("ss_busy", busy, 0);
        chk("ss_n", q_data.size(), 0);

        // continuous frames with frame gap 3, stopped after third frame
        do_reset();
        set_cfg(2'd1, 16'd10, 12'd2, 8'd0, 12'd3, 1'b1);
        go(s);
        for (int t = 0; t < 60 && frame_cnt != 16'd3; t++) @(negedge clk);
        pulse_stop();
        repeat (10) @(negedge clk);
        chk("cont_n", q_data.size(), 6);
        for (int i = 0; i < q_data.size(); i++) begin
            chk("cont_cyc", q_cyc[i], s + 1 + 5 * (i / 2) + (i % 2));
            chk("cont_data", q_data[i], 10 + (i % 2));
            chk("cont_fd", q_fd[i], i % 2);
        end
        chk("cont_fcnt", frame_cnt, 3);
        chk("cont_busy", busy, 0);

        // stop during the gap after the second of five samples
        do_reset();
        set_cfg(2'd1, 16'd0, 12'd5, 8'd3, 12'd0, 1'b0);
        go(s);
        for (int t = 0; t < 40 && !(valid && sample_idx == 12'd1); t++) @(negedge clk);
        pulse_stop();
        repeat (30) @(negedge clk);
        chk("stop_n", q_data.size(), 2);
        fd_sum = 0;
        foreach (q_fd[i]) fd_sum += int'(q_fd[i]);
        chk("stop_fd", fd_sum, 0);
        chk("stop_fcnt", frame_cnt, 0);
        chk("stop_busy", busy, 0);

        // single-sample continuous frames: frame_done with every valid
        do_reset();
        set_cfg(2'd1, 16'd7, 12'd1, 8'd0, 12'd0, 1'b1);
        go(s);
        for (int t = 0; t < 40 && frame_cnt != 16'd4; t++) @(negedge clk);
        pulse_stop();
        repeat (5) @(negedge clk);
        chk("one_n", q_data.size(), 4);
        for (int i = 0; i < q_data.size(); i++) begin
            chk("one_fd", q_fd[i], 1);
            chk("one_idx", q_idx[i], 0);
            chk("one_data", q_data[i], 7);
            chk("one_cyc", q_cyc[i], s + 1 + i);
        end
        chk("one_fcnt", frame_cnt, 4);

        // reset mid-frame
        do_reset();
        set_cfg(2'd1, 16'd0, 12'd10, 8'd1, 12'd0, 1'b0);
        go(s);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_valid", valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_data", lidar_data, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mrst_n", q_data.size(), 2);
        chk("mrst_fcnt", frame_cnt, 0);

        // mode 2
        do_reset();
        set_cfg(2'd2, 16'd0, 12'd4, 8'd0, 12'd0, 1'b0);
        go(s);
        repeat (10) @(negedge clk);
        chk("m2_n", q_data.size(), 4);
        m = 16'hACE1;
        for (int i = 0; i < q_data.size(); i++) begin
`ifdef LIDAR_GEN_LFSR_EN
            chk("m2_lfsr", q_data[i], m);
            m = lfsr_next(m);
`else
            chk("m2_ramp", q_data[i], i);
`endif
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
